elbeth_alu_seq: RTL and testbench

//  Parametrised multi-cycle execution unit for the ELBETH EX stage. Covers the base RV32I ALU ops

---
 rtl/elbeth_alu_seq_if.sv | 33 +++
 rtl/elbeth_alu_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_elbeth_alu_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/elbeth_alu_seq_if.sv
// ----------------------------------------------------------------------------
// elbeth_alu_seq_if
//   Handshake bundle between the EX stage (master) and the multi-cycle
//   execution unit (slave).
//
//   Issue side  : in_valid, in_ready, data_a, data_b, operation
//   Result side : out_valid, out_ready, alu_result, illegal_op
// ----------------------------------------------------------------------------
interface elbeth_alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [4:0]       operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             illegal_op;

    // Producer of operations / consumer of results (EX pipeline control).
    modport master (
        output in_valid, data_a, data_b, operation, out_ready,
        input  in_ready, out_valid, alu_result, illegal_op
    );

    // The execution unit itself.
    modport slave (
        input  in_valid, data_a, data_b, operation, out_ready,
        output in_ready, out_valid, alu_result, illegal_op
    );
endinterface

// File: rtl/elbeth_alu_seq.sv
// ----------------------------------------------------------------------------
// elbeth_alu_seq
//   Multi-cycle execution unit for the ELBETH EX stage. Single-cycle RV32I
//   ALU ops, iterative shift-add multiply and restoring divide (one bit per
//   cycle), valid/ready on both sides and a flush that kills in-flight work.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high (overrides everything)
//   flush  in   synchronous abort of any accepted / in-flight op
//   bus    slave modport of elbeth_alu_seq_if (operands, op, result)
// ----------------------------------------------------------------------------
module elbeth_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    elbeth_alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    // Last iteration index; the step taken at this count also produces the result.
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLTU   = 5'd5;
    localparam logic [4:0] OP_SLT    = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [SHW:0]       r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_opnd;     // mul: multiplicand magnitude; div: divisor magnitude
    logic               r_is_div;
    logic               r_is_rem;
    logic               r_mul_lo;
    logic               r_neg_q;    // product / quotient must be negated at the end
    logic               r_neg_r;    // remainder must be negated (dividend sign)
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_illegal;

    // ------------------------------------------------------------------
    // Issue-side decode (operands straight from the bus)
    // ------------------------------------------------------------------
    logic [4:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [SHW-1:0]   w_shamt;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_rem;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_long;
    logic [WIDTH-1:0] w_short_result;
    logic             w_illegal;

    assign w_op     = bus.operation;
    assign w_a      = bus.data_a;
    assign w_b      = bus.data_b;
    assign w_shamt  = w_b[SHW-1:0];
    assign w_is_mul = (w_op[4:2] == 3'b100);
    assign w_is_div = (w_op[4:2] == 3'b101);
    assign w_is_rem = w_op[1];

    assign w_a_neg  = w_a[WIDTH-1] &
                      ((w_op == OP_MULH) | (w_op == OP_MULHSU) | (w_op == OP_DIV) | (w_op == OP_REM));
    assign w_b_neg  = w_b[WIDTH-1] &
                      ((w_op == OP_MULH) | (w_op == OP_DIV) | (w_op == OP_REM));
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_a_mag  = w_a_neg ? -w_a : w_a;
    assign w_b_mag  = w_b_neg ? -w_b : w_b;

    assign w_div_zero = w_is_div & (w_b == '0);
    assign w_div_ovf  = ((w_op == OP_DIV) | (w_op == OP_REM)) &
                        (w_a == {1'b1, {(WIDTH-1){1'b0}}}) & (w_b == '1);
    assign w_long     = w_is_mul | (w_is_div & ~w_div_zero & ~w_div_ovf);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_short_result = '0;
        w_illegal      = 1'b0;
        case (w_op)
            OP_ADD:  w_short_result = w_a + w_b;
            OP_SUB:  w_short_result = w_a - w_b;
            OP_AND:  w_short_result = w_a & w_b;
            OP_OR:   w_short_result = w_a | w_b;
            OP_XOR:  w_short_result = w_a ^ w_b;
            OP_SLTU: w_short_result = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            OP_SLT:  w_short_result = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            OP_SLL:  w_short_result = w_a << w_shamt;
            OP_SRL:  w_short_result = w_a >> w_shamt;
            OP_SRA:  w_short_result = WIDTH'($signed(w_a) >>> w_shamt);
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_short_result = '0;   // always iterative
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                // Only the fast paths land here; the normal case goes to BUSY.
                if (w_div_zero)
                    w_short_result = w_is_rem ? w_a : '1;
                else if (w_div_ovf)
                    w_short_result = w_is_rem ? '0 : w_a;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration step and final sign correction
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_long_result;

    // Multiply: add multiplicand if multiplier LSB set, shift the pair right.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};

    assign w_acc_step = r_is_div
        ? (w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                              : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
        : {w_mul_sum, r_acc[WIDTH-1:1]};

    assign w_prod = r_neg_q ? -w_acc_step : w_acc_step;
    assign w_quo  = w_acc_step[WIDTH-1:0];
    assign w_rem  = w_acc_step[2*WIDTH-1:WIDTH];

    always_comb begin
        w_long_result = '0;
        if (!r_is_div)
            w_long_result = r_mul_lo ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
        else if (r_is_rem)
            w_long_result = r_neg_r ? -w_rem : w_rem;
        else
            w_long_result = r_neg_q ? -w_quo : w_quo;
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opnd      <= '0;
            r_is_div    <= 1'b0;
            r_is_rem    <= 1'b0;
            r_mul_lo    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // in_ready is implied here: IDLE, no flush, no reset.
                    if (bus.in_valid) begin
                        if (w_long) begin
                            r_state  <= S_BUSY;
                            r_cnt    <= '0;
                            r_is_div <= w_is_div;
                            r_is_rem <= w_is_rem;
                            r_mul_lo <= (w_op == OP_MUL);
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            if (w_is_div) begin
                                r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opnd <= w_b_mag;
                            end else begin
                                r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                                r_opnd <= w_a_mag;
                            end
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_short_result;
                            r_illegal   <= w_illegal;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_long_result;
                        r_illegal   <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE) & ~flush & ~rst;
    assign bus.out_valid  = r_out_valid;
    assign bus.alu_result = r_result;
    assign bus.illegal_op = r_illegal;

endmodule

// File: tb/tb_elbeth_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_elbeth_alu_seq
//   Directed vectors for elbeth_alu_seq (WIDTH=32). The issue task pushes the
//   expected result, illegal flag and latency into a scoreboard; a monitor on
//   the falling edge pops and compares on every result handshake.
// ----------------------------------------------------------------------------
module tb_elbeth_alu_seq;
    localparam int W = 32;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLTU   = 5'd5;
    localparam logic [4:0] OP_SLT    = 5'd6;
    localparam logic [4:0] OP_SLL    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    elbeth_alu_seq_if #(.WIDTH(W)) bus ();

    elbeth_alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] result;
        logic         illegal;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   seen   = 1'b0;
    int   first_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Result monitor: latency is first out_valid cycle minus accept cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (bus.out_ready) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_result");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_result"},  bus.alu_result, e.result);
                    check({e.name, "_illegal"}, bus.illegal_op, e.illegal);
                    check({e.name, "_latency"}, first_cyc - e.acc_cyc, e.lat);
                end
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input string name, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_ill,
                         input int lat, input bit push);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.operation = op;
        bus.data_a    = a;
        bus.data_b    = b;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            timeout({name, "_accept"});
            bus.in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.name    = name;
            e.result  = exp_r;
            e.illegal = exp_ill;
            e.lat     = lat;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            timeout({name, "_drain"});
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rose;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_a    = '0;
        bus.data_b    = '0;
        bus.operation = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid,  0);
        check("rst_result",    bus.alu_result, 0);
        check("rst_illegal",   bus.illegal_op, 0);
        check("rst_in_ready",  bus.in_ready,   0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);

        // Single-cycle ALU ops
        issue("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, 1'b1);
        issue("sra",      OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1, 1'b1);
        issue("sub_wrap", OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1, 1'b1);
        issue("and",      OP_AND,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1, 1'b1);
        issue("or",       OP_OR,   32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1, 1'b1);
        issue("xor",      OP_XOR,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1, 1'b1);
        issue("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, 1'b1);
        issue("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, 1'b1);
        issue("sll",      OP_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1, 1'b1);
        issue("srl",      OP_SRL,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0, 1, 1'b1);
        issue("ill_12",   5'd12,   32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1, 1'b1);

        // Iterative multiply
        issue("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, W+1, 1'b1);
        issue("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, W+1, 1'b1);
        issue("mul",    OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, W+1, 1'b1);
        issue("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, W+1, 1'b1);

        // Iterative divide and fast paths
        issue("div",      OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, W+1, 1'b1);
        issue("rem",      OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, W+1, 1'b1);
        issue("divu",     OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, W+1, 1'b1);
        issue("remu",     OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, W+1, 1'b1);
        issue("divu_z",   OP_DIVU, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1, 1'b1);
        issue("remu_z",   OP_REMU, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1'b0, 1, 1'b1);
        issue("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1, 1'b1);
        issue("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b1);
        drain("directed");

        // Backpressure: result held in DONE, nothing accepted
        bus.out_ready = 1'b0;
        issue("bp_add", OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid,  1);
            check("bp_result",    bus.alu_result, 32'd30);
            check("bp_in_ready",  bus.in_ready,   0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        drain("backpressure");

        // Flush in the middle of a DIVU
        issue("divu_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, W+1, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", bus.in_ready, 1);
        rose = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) rose = 1'b1;
        end
        check("flush_no_out_valid", rose, 0);
        issue("add_after_flush", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b1);
        drain("flush");

        // Reset in the middle of a MUL, then an unknown op code
        issue("mul_rst", OP_MUL, 32'd7, 32'd9, 32'd63, 1'b0, W+1, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid,  0);
        check("midrst_result",    bus.alu_result, 0);
        check("midrst_in_ready",  bus.in_ready,   0);
        rst = 1'b0;
        issue("ill_31", 5'd31, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1, 1'b1);
        drain("reset");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
